// File: rtl/pwm_capture.sv
// PWM capture: recovers the duty level of a PWM input by counting high samples
// over free-running windows of 2^WINDOW_BITS clocks.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_in,
    output logic [WINDOW_BITS-1:0] level,
    output logic                   valid,
    output logic                   saturated,
    output logic                   stuck,
    output logic                   dbg_state_o,
    output logic [WINDOW_BITS-1:0] dbg_win_cnt_o
);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam logic [WINDOW_BITS-1:0] WIN_LAST = '1;
    localparam logic [WINDOW_BITS:0]   FULL     = {1'b1, {WINDOW_BITS{1'b0}}};

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_s_q;
    logic [WINDOW_BITS-1:0]   win_cnt_q, win_cnt_d;
    logic [WINDOW_BITS:0]     high_cnt_q, high_cnt_d;
    logic                     seen_edge_q, seen_edge_d;
    logic [WINDOW_BITS-1:0]   level_q, level_d;
    logic                     valid_q, valid_d;
    logic                     saturated_q, saturated_d;
    logic                     stuck_q, stuck_d;

    logic                     s;
    logic                     edge_det;
    logic                     last_cycle;
    logic [WINDOW_BITS:0]     total;
    logic                     any_edge;

    assign s          = sync_q[SYNC_STAGES-1];
    assign edge_det   = s ^ prev_s_q;
    assign last_cycle = (win_cnt_q == WIN_LAST);
    // The sample taken on the last cycle still belongs to the ending window.
    assign total      = high_cnt_q + {{WINDOW_BITS{1'b0}}, s};
    assign any_edge   = seen_edge_q | edge_det;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            prev_s_q    <= 1'b0;
            state_q     <= ST_WARMUP;
            win_cnt_q   <= '0;
            high_cnt_q  <= '0;
            seen_edge_q <= 1'b0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            saturated_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_s_q    <= s;
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            high_cnt_q  <= high_cnt_d;
            seen_edge_q <= seen_edge_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            saturated_q <= saturated_d;
            stuck_q     <= stuck_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q + 1'b1;
        high_cnt_d  = total;
        seen_edge_d = any_edge;
        level_d     = level_q;
        valid_d     = 1'b0;
        saturated_d = saturated_q;
        stuck_d     = stuck_q;

        if (last_cycle) begin
            high_cnt_d  = '0;
            seen_edge_d = 1'b0;
            unique case (state_q)
                // First window holds synchronizer reset zeros, so it is dropped.
                ST_WARMUP: state_d = ST_RUN;
                ST_RUN: begin
                    level_d     = (total == FULL) ? WIN_LAST : total[WINDOW_BITS-1:0];
                    saturated_d = (total == FULL);
                    stuck_d     = !any_edge;
                    valid_d     = 1'b1;
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    assign level         = level_q;
    assign valid         = valid_q;
    assign saturated     = saturated_q;
    assign stuck         = stuck_q;
    assign dbg_state_o   = (state_q == ST_RUN);
    assign dbg_win_cnt_o = win_cnt_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: randomized PWM sources checked every cycle against a
// window-sum model computed from the recorded input history.
module tb_pwm_capture;

    localparam int W    = 8;
    localparam int WIN  = 1 << W;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pwm_in = 1'b0;
    logic [W-1:0] level;
    logic         valid;
    logic         saturated;
    logic         stuck;
    logic         dbg_state;
    logic [W-1:0] dbg_win_cnt;

    pwm_capture #(.SYNC_STAGES(SYNC), .WINDOW_BITS(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .pwm_in        (pwm_in),
        .level         (level),
        .valid         (valid),
        .saturated     (saturated),
        .stuck         (stuck),
        .dbg_state_o   (dbg_state),
        .dbg_win_cnt_o (dbg_win_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Generator: high while (gen_cnt mod gen_period) < gen_level.
    int gen_cnt    = 0;
    int gen_period = WIN;
    int gen_level  = 0;

    // Model state: pwm_in history since reset release, expected held outputs.
    logic in_hist[$];
    int   cyc = -1;
    int   exp_level = 0;
    int   exp_sat   = 0;
    int   exp_stuck = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int s_at(input int k);
        if (k < SYNC) return 0;
        return int'(in_hist[k - SYNC]);
    endfunction

    // Outputs after window n close at cycle 256*(n+1); window 0 is discarded.
    task automatic model_window(input int n);
        int base, cnt, first, same;
        base = n * WIN;
        cnt  = 0;
        same = 1;
        first = s_at(base - 1);
        for (int k = base; k < base + WIN; k++) begin
            cnt += s_at(k);
            if (s_at(k) != first) same = 0;
        end
        exp_level = (cnt == WIN) ? WIN - 1 : cnt;
        exp_sat   = (cnt == WIN) ? 1 : 0;
        exp_stuck = same;
    endtask

    task automatic step();
        int exp_valid;
        cyc++;
        pwm_in = ((gen_cnt % gen_period) < gen_level);
        gen_cnt++;
        in_hist.push_back(pwm_in);
        exp_valid = 0;
        if (cyc >= 2 * WIN && cyc % WIN == 0) begin
            model_window(cyc / WIN - 1);
            exp_valid = 1;
        end
        check_val("valid", int'(valid), exp_valid);
        check_val("level", int'(level), exp_level);
        check_val("saturated", int'(saturated), exp_sat);
        check_val("stuck", int'(stuck), exp_stuck);
        check_val("state_run", int'(dbg_state), (cyc >= WIN) ? 1 : 0);
        check_val("win_cnt", int'(dbg_win_cnt), cyc % WIN);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step();
        end
    endtask

    // Advance until the last processed cycle is in RUN at window phase ph.
    task automatic run_to(input int ph);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            step();
            guard++;
        end while (!(cyc >= 2 * WIN && cyc % WIN == ph) && guard < 2000);
        check_val("run_to_timeout", guard < 2000 ? 1 : 0, 1);
    endtask

    // Caller raises reset at a negedge; hold it for n sampled edges, then release.
    task automatic hold_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("rst_valid", int'(valid), 0);
            check_val("rst_level", int'(level), 0);
            check_val("rst_saturated", int'(saturated), 0);
            check_val("rst_stuck", int'(stuck), 0);
            check_val("rst_state_run", int'(dbg_state), 0);
            check_val("rst_win_cnt", int'(dbg_win_cnt), 0);
        end
        reset = 1'b0;
        in_hist.delete();
        cyc = -1;
        exp_level = 0;
        exp_sat   = 0;
        exp_stuck = 0;
        step();
    endtask

    task automatic set_gen(input int period, input int lvl);
        gen_period = period;
        gen_level  = lvl;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gen_cnt = $urandom_range(0, 1023);
        set_gen(WIN, 8'h40);
        @(negedge clk);
        hold_reset(3);

        // Nominal level, first valid at cycle 512 is covered cycle by cycle.
        run(2 * WIN + 3 * WIN);
        check_val("lvl40_level", int'(level), 64);
        check_val("lvl40_sat", int'(saturated), 0);
        check_val("lvl40_stuck", int'(stuck), 0);

        set_gen(WIN, 0);
        run(3 * WIN);
        check_val("low_level", int'(level), 0);
        check_val("low_sat", int'(saturated), 0);
        check_val("low_stuck", int'(stuck), 1);

        set_gen(WIN, WIN);
        run(3 * WIN);
        check_val("high_level", int'(level), 255);
        check_val("high_sat", int'(saturated), 1);
        check_val("high_stuck", int'(stuck), 1);

        set_gen(WIN, WIN - 1);
        run(3 * WIN);
        check_val("lvl255_level", int'(level), 255);
        check_val("lvl255_sat", int'(saturated), 0);
        check_val("lvl255_stuck", int'(stuck), 0);

        set_gen(WIN, 1);
        run(3 * WIN);
        check_val("lvl1_level", int'(level), 1);
        check_val("lvl1_stuck", int'(stuck), 0);

        // Mid-window step 10 -> 200.
        set_gen(WIN, 10);
        run(2 * WIN);
        run_to(128);
        set_gen(WIN, 200);
        run(3 * WIN);
        check_val("step_level", int'(level), 200);

        // Reset mid-window during RUN.
        set_gen(WIN, 77);
        run_to(100);
        hold_reset(3);
        run(2 * WIN + WIN);
        check_val("after_rst_level", int'(level), 77);

        // Reset coinciding with the last window cycle.
        run_to(WIN - 1);
        hold_reset(1);
        run(2 * WIN + 10);

        // Random periods, levels and phases, with occasional resets.
        for (int it = 0; it < 16; it++) begin
            int p;
            p = $urandom_range(2, 400);
            set_gen(p, $urandom_range(0, p));
            gen_cnt = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) == 0) begin
                run_to($urandom_range(0, WIN - 1));
                hold_reset($urandom_range(1, 4));
            end
            run($urandom_range(2 * WIN, 4 * WIN));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive end of the 8-bit PWM link: takes a PWM waveform (period 2^WINDOW_BITS clocks) and recovers the duty level.
- Counts high samples over fixed free-running windows of 2^WINDOW_BITS clocks.
- For a periodic input of that period, the high count equals the transmitted level exactly, independent of phase.
- Used for loopback checking of the PWM outputs and for reading external PWM sources into the mixer.

Parameters:
- SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (>=2).
- WINDOW_BITS, 8, log2 of the window length; also the width of level.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pwm_in  input  1  PWM waveform, asynchronous to clk
- level  output  WINDOW_BITS  recovered duty level, held between updates
- valid  output  1  one-cycle pulse when level/saturated/stuck update
- saturated  output  1  last window was high every cycle (count = 2^WINDOW_BITS)
- stuck  output  1  last window had no transition on the synchronized input

Behaviour:
- Clock, reset and outputs:
  - Single clock clk. Reset is synchronous and active-high on port reset.
  - All state is cleared on reset.
  - Reset values: level=0, valid=0, saturated=0, stuck=0. Synchronizer flops=0, win_cnt=0, high_cnt=0, state=WARMUP.
- Synchronizer:
  - pwm_in passes through SYNC_STAGES flops to give s; prev_s is s delayed one cycle.
  - Latency from pwm_in to s is SYNC_STAGES cycles.
  - edge = s XOR prev_s.
- Window counter:
  - win_cnt is WINDOW_BITS wide and increments every non-reset cycle, wrapping from 2^W-1 to 0.
  - The window is the cycles where win_cnt runs 0..2^W-1.
- High and edge accumulation:
  - high_cnt is WINDOW_BITS+1 bits wide.
  - Each cycle high_cnt += s, except on the last cycle.
  - seen_edge is set by edge, except on the last cycle.
- Last cycle (win_cnt==2^W-1), compute:
  - total = high_cnt + s, in WINDOW_BITS+1 bits.
  - any_edge = seen_edge | edge.
  - Then clear high_cnt=0 and seen_edge=0 for the next window. The sample on this cycle belongs to the ending window.
- FSM:
  - WARMUP: at the last cycle, go to RUN. No output update and valid stays 0. The first window is discarded because it contains synchronizer reset zeros.
  - RUN: at the last cycle, register the outputs and pulse valid. Stay in RUN.
  - Any reset returns to WARMUP.
- Output update in RUN:
  - level <= (total == 2^W) ? 2^W-1 : total[W-1:0].
  - saturated <= (total == 2^W).
  - stuck <= !any_edge.
  - valid <= 1 for exactly one cycle. It is high in the cycle after the last window cycle, aligned with the new level.
- Timing:
  - Counting non-reset cycles from 0 after reset deasserts, the first valid is high in cycle 2^(W+1) (512 for W=8).
  - After that, valid pulses every 2^W cycles.
  - Outputs hold their values between pulses.
- Boundary conditions:
  - Level change mid-window gives exactly one transitional result (a mix of old and new), then the new value.
  - Constant-low input: level=0, saturated=0, stuck=1.
  - Constant-high input: level=2^W-1, saturated=1, stuck=1.
  - Transmit level 2^W-1 (one low cycle per period): level=2^W-1, saturated=0, stuck=0.
  - Reset mid-window discards partial counts. valid stays 0 for 2^(W+1) cycles after reset release.
  - Reset asserted in the same cycle as the last window cycle: reset wins, no valid.
  - Input period other than 2^W: level is the high count per window. Not an error; no period check.

Test Plan:
- Drive pwm_in from a W=8 PWM generator with level=0x40, arbitrary phase -> valid every 256 cycles with level=64, saturated=0, stuck=0. First valid exactly at cycle 512.
- Generator level=0 (constant low) -> level=0, saturated=0, stuck=1. Then force pwm_in=1 constantly -> after one transitional window, level=255, saturated=1, stuck=1.
- Generator level=255 -> level=255, saturated=0, stuck=0. Level=1 -> level=1, stuck=0.
- Change generator level 10->200 mid-window -> results 10, then one value between 10 and 200, then 200 on every later valid.
- Assert reset for 3 cycles at win_cnt=100 during RUN -> all outputs 0 during reset. No valid for the next 511 cycles; valid at cycle 512 with the correct level.
- Pulse reset on the last window cycle -> no valid that cycle; state=WARMUP, win_cnt=0 next cycle.
